i2c_arbiter: RTL

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/rr_pick.sv | 32 +++
 rtl/i2c_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C master arbiter: FSM encoding, status codes, address width.
// BACKOFF exists only when I2C_ARB_RETRY_EN is defined.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;

  typedef enum logic [1:0] {
    ERR_OK   = 2'b00,
    ERR_NACK = 2'b01,
    ERR_TMO  = 2'b10
  } err_e;

`ifdef I2C_ARB_RETRY_EN
  typedef enum logic [2:0] {IDLE, ARB, LAUNCH, WAIT, RESP, BACKOFF} arb_state_e;
`else
  typedef enum logic [2:0] {IDLE, ARB, LAUNCH, WAIT, RESP} arb_state_e;
`endif

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching upward from last+1 (mod NREQ).
module rr_pick
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = IW'((32'(last) + k) % NREQ);
      if (!valid && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ requesters, with timeout abort.
// Define I2C_ARB_RETRY_EN to retry NACKed transactions after a backoff interval.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned BACKOFF_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [ADDR_W*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0]      req_wdata,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [1:0]             err,
  output logic [7:0]             rdata,
  output logic                   m_ena,
  output logic                   m_rw,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [7:0]             m_wdata,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic                   m_nack,
  input  logic [7:0]             m_rdata
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned TW = idx_w(TIMEOUT_CYC);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2 || BACKOFF_CYC < 1 || MAX_RETRY > 255)
  begin : g_bad_cfg
    $error("i2c_arbiter: unsupported parameter combination");
  end

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [IW-1:0]     own_q, own_d;
  logic [IW-1:0]     last_q, last_d;
  err_e              err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              m_ena_q, m_ena_d;
  logic              m_rw_q, m_rw_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [7:0]        m_wdata_q, m_wdata_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              can_retry;

  logic [NREQ-1:0]   pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;

`ifdef I2C_ARB_RETRY_EN
  localparam int unsigned RW = idx_w(MAX_RETRY + 1);
  localparam int unsigned BW = idx_w(BACKOFF_CYC);
  logic [RW-1:0] retry_q, retry_d;
  logic [BW-1:0] bo_q, bo_d;
  assign can_retry = (retry_q < RW'(MAX_RETRY));
`else
  assign can_retry = 1'b0;
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    own_d     = own_q;
    last_d    = last_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    m_ena_d   = 1'b0;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    cnt_d     = cnt_q;
`ifdef I2C_ARB_RETRY_EN
    retry_d   = retry_q;
    bo_d      = bo_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Grant and command are captured here so they are visible throughout ARB.
        if (pick_valid && !m_busy) begin
          state_d = ARB;
          grant_d = pick_gnt;
          own_d   = pick_idx;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
              m_rw_d    = req_rw[i];
              m_addr_d  = req_addr[ADDR_W*i +: ADDR_W];
              m_wdata_d = req_wdata[8*i +: 8];
            end
          end
`ifdef I2C_ARB_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      ARB: begin
        state_d = LAUNCH;
        m_ena_d = 1'b1;
      end
      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // m_done wins over a timeout expiring in the same cycle.
        if (m_done) begin
          if (!m_nack) begin
            state_d = RESP;
            err_d   = ERR_OK;
            rdata_d = m_rdata;
            done_d  = grant_q;
          end else if (can_retry) begin
`ifdef I2C_ARB_RETRY_EN
            state_d = BACKOFF;
            bo_d    = '0;
`endif
          end else begin
            state_d = RESP;
            err_d   = ERR_NACK;
            done_d  = grant_q;
          end
        end else if (cnt_q == TW'(TIMEOUT_CYC - 2)) begin
          state_d = RESP;
          err_d   = ERR_TMO;
          done_d  = grant_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
        last_d  = own_q;
      end
`ifdef I2C_ARB_RETRY_EN
      BACKOFF: begin
        bo_d = bo_q + 1'b1;
        if (bo_q == BW'(BACKOFF_CYC - 1)) begin
          state_d = LAUNCH;
          m_ena_d = 1'b1;
          retry_d = retry_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      own_q     <= '0;
      last_q    <= IW'(NREQ - 1);
      err_q     <= ERR_OK;
      rdata_q   <= '0;
      m_ena_q   <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      cnt_q     <= '0;
`ifdef I2C_ARB_RETRY_EN
      retry_q   <= '0;
      bo_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      own_q     <= own_d;
      last_q    <= last_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      m_ena_q   <= m_ena_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      cnt_q     <= cnt_d;
`ifdef I2C_ARB_RETRY_EN
      retry_q   <= retry_d;
      bo_q      <= bo_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign m_ena   = m_ena_q;
  assign m_rw    = m_rw_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule
